cache_refill: RTL

Miss-service engine for the MMU page cache: the responder on the cache-miss interface. When the cache front end detects a miss it raises a refill request with the missing page number and the victim slot. This block invalidates that slot's tag, copies the whole page from external memory into the cache SRAM, then commits the new tag. It sits between the cache lookup/phi2 sequencer, the external memory bus and the on-board cache SRAM, and runs entirely on `fpgaClk`.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/refill_watchdog.sv | 30 +++
 rtl/cache_refill.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the MMU page cache: geometry constants, the refill
// state encoding and the miss-interface handshake used by lookup and refill.
package cache_pkg;

    localparam int PAGE_BITS = 10;
    localparam int SLOT_BITS = 2;
    localparam int TAG_BITS  = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INVAL,
        ST_FETCH,
        ST_WRITE,
        ST_COMMIT,
        ST_ACK
    } refillState_t;

    typedef struct packed {
        logic req;
        logic ack;
    } missHs_t;

endpackage

// File: rtl/refill_watchdog.sv
// Per-read watchdog for the refill engine: counts stalled FETCH cycles and
// flags expiry. Only built when CACHE_REFILL_TIMEOUT_EN is defined.
`ifdef CACHE_REFILL_TIMEOUT_EN
module refill_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic fpgaClk,
    input  logic fpgaRst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge fpgaClk) begin
        if (fpgaRst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th stalled cycle so the FSM leaves FETCH on that edge.
    assign expire = en && (count == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/cache_refill.sv
// Cache miss-service engine: invalidate victim slot, copy one page from external
// memory into cache SRAM, commit the tag. Optional watchdog: CACHE_REFILL_TIMEOUT_EN.
module cache_refill
    import cache_pkg::*;
#(
    parameter int PAGE_BITS = cache_pkg::PAGE_BITS,
    parameter int SLOT_BITS = cache_pkg::SLOT_BITS,
    parameter int TAG_BITS  = cache_pkg::TAG_BITS,
    parameter int TIMEOUT   = 255
) (
    input  logic                          fpgaClk,
    input  logic                          fpgaRst,
    input  logic                          missReq,
    input  logic [TAG_BITS-1:0]           missPage,
    input  logic [SLOT_BITS-1:0]          missSlot,
    output logic                          missAck,
    output logic                          missErr,
    output logic                          busy,
    output logic                          tagWe,
    output logic                          tagValid,
    output logic [SLOT_BITS-1:0]          tagSlot,
    output logic [TAG_BITS-1:0]           tagPage,
    output logic                          extRd,
    output logic [TAG_BITS+PAGE_BITS-1:0] extAddr,
    input  logic [7:0]                    extData,
    input  logic                          extValid,
    output logic                          sramWe,
    output logic [SLOT_BITS+PAGE_BITS-1:0] sramAddr,
    output logic [7:0]                    sramData
);

    refillState_t state, nextState;

    logic [TAG_BITS-1:0]  pageLat, pageNext;
    logic [SLOT_BITS-1:0] slotLat, slotNext;
    logic [PAGE_BITS-1:0] offset, offsetNext;
    logic [7:0]           byteLat, byteNext;
    logic                 errLat, errNext;
    logic                 lastByte;
    logic                 timeoutHit;

    logic                          missAckD, missErrD, busyD, tagWeD, tagValidD;
    logic [SLOT_BITS-1:0]          tagSlotD;
    logic [TAG_BITS-1:0]           tagPageD;
    logic                          extRdD, sramWeD;
    logic [TAG_BITS+PAGE_BITS-1:0] extAddrD;
    logic [SLOT_BITS+PAGE_BITS-1:0] sramAddrD;
    logic [7:0]                    sramDataD;

    assign lastByte = (offset == '1);

`ifdef CACHE_REFILL_TIMEOUT_EN
    logic wdClr, wdEn;

    assign wdEn  = (state == ST_FETCH) && !extValid;
    // Every entry to FETCH comes from INVAL or WRITE, so clearing there restarts each read.
    assign wdClr = (state == ST_INVAL) || (state == ST_WRITE);

    refill_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) uWatchdog (
        .fpgaClk(fpgaClk),
        .fpgaRst(fpgaRst),
        .clr    (wdClr),
        .en     (wdEn),
        .expire (timeoutHit)
    );
`else
    // TIMEOUT only sizes the watchdog; keep it referenced when the watchdog is absent.
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT != 0);
    assign timeoutHit    = 1'b0;
`endif

    always_ff @(posedge fpgaClk) begin
        if (fpgaRst) begin
            state    <= ST_IDLE;
            missAck  <= 1'b0;
            missErr  <= 1'b0;
            busy     <= 1'b0;
            tagWe    <= 1'b0;
            tagValid <= 1'b0;
            tagSlot  <= '0;
            tagPage  <= '0;
            extRd    <= 1'b0;
            extAddr  <= '0;
            sramWe   <= 1'b0;
            sramAddr <= '0;
            sramData <= '0;
        end else begin
            state    <= nextState;
            missAck  <= missAckD;
            missErr  <= missErrD;
            busy     <= busyD;
            tagWe    <= tagWeD;
            tagValid <= tagValidD;
            tagSlot  <= tagSlotD;
            tagPage  <= tagPageD;
            extRd    <= extRdD;
            extAddr  <= extAddrD;
            sramWe   <= sramWeD;
            sramAddr <= sramAddrD;
            sramData <= sramDataD;
        end
    end

    always_ff @(posedge fpgaClk) begin
        pageLat <= pageNext;
        slotLat <= slotNext;
        offset  <= offsetNext;
        byteLat <= byteNext;
        errLat  <= errNext;
    end

    always_comb begin
        nextState  = state;
        pageNext   = pageLat;
        slotNext   = slotLat;
        offsetNext = offset;
        byteNext   = byteLat;
        errNext    = errLat;
        case (state)
            ST_IDLE: begin
                if (missReq) begin
                    nextState  = ST_INVAL;
                    pageNext   = missPage;
                    slotNext   = missSlot;
                    offsetNext = '0;
                    errNext    = 1'b0;
                end
            end
            ST_INVAL:  nextState = ST_FETCH;
            ST_FETCH: begin
                if (extValid) begin
                    nextState = ST_WRITE;
                    byteNext  = extData;
                end else if (timeoutHit) begin
                    nextState = ST_ACK;
                    errNext   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (lastByte) begin
                    nextState = ST_COMMIT;
                end else begin
                    nextState  = ST_FETCH;
                    offsetNext = offset + 1'b1;
                end
            end
            ST_COMMIT: begin
                nextState = ST_ACK;
                errNext   = 1'b0;
            end
            ST_ACK: begin
                if (!missReq) begin
                    nextState = ST_IDLE;
                end
            end
            default:   nextState = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        missAckD  = (nextState == ST_ACK);
`ifdef CACHE_REFILL_TIMEOUT_EN
        missErrD  = (nextState == ST_ACK) && errNext;
`else
        missErrD  = 1'b0;
`endif
        busyD     = (nextState != ST_IDLE);
        tagWeD    = (nextState == ST_INVAL) || (nextState == ST_COMMIT);
        tagValidD = (nextState == ST_COMMIT);
        tagSlotD  = tagWeD ? slotNext : '0;
        tagPageD  = tagValidD ? pageNext : '0;
        extRdD    = (nextState == ST_FETCH);
        extAddrD  = extRdD ? {pageNext, offsetNext} : '0;
        sramWeD   = (nextState == ST_WRITE);
        sramAddrD = sramWeD ? {slotNext, offsetNext} : '0;
        sramDataD = sramWeD ? byteNext : '0;
    end

endmodule
